// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the Mini-ALU compare path.
//   cmp_op_e     : relational opcode encodings (3 bits, 3'b11x reserved)
//   MAX_W        : widest operand ext_operand() can handle
//   ext_operand  : sign/zero extends an operand of 'width' bits by one guard
//                  bit, so the result is meaningful in bits [width:0]
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [2:0] {
    CMP_LT   = 3'b000,
    CMP_LE   = 3'b001,
    CMP_EQ   = 3'b010,
    CMP_NE   = 3'b011,
    CMP_GT   = 3'b100,
    CMP_GE   = 3'b101,
    CMP_RSVD = 3'b110
  } cmp_op_e;

  // Caller passes the operand zero-extended to MAX_W bits; every bit from
  // 'width' upward is replaced with the fill bit (operand MSB when signed).
  function automatic logic [MAX_W:0] ext_operand(input logic [MAX_W-1:0] value,
                                                 input int              width,
                                                 input logic            is_signed);
    logic [MAX_W:0] ext;
    logic           fill;
    fill = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) fill = value[i];
    end
    fill = fill & is_signed;
    ext  = {1'b0, value};
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= width) ext[i] = fill;
    end
    ext[MAX_W] = fill;
    return ext;
  endfunction

endpackage

// File: rtl/alu_compare_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_compare_pipe_if
// Bundles the operand handshake, result handshake and counter signals of
// alu_compare_pipe.
//   master : the side that issues operands and consumes results
//   slave  : the comparator itself
// ----------------------------------------------------------------------------
interface alu_compare_pipe_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic             out_lt;
  logic             out_eq;
  logic             out_gt;
  logic             out_err;
  logic             cnt_clr;
  logic [CNT_W-1:0] true_count;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_op, out_ready, cnt_clr,
    input  in_ready, out_valid, out_result, out_lt, out_eq, out_gt, out_err,
           true_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_op, out_ready, cnt_clr,
    output in_ready, out_valid, out_result, out_lt, out_eq, out_gt, out_err,
           true_count
  );

endinterface

// File: rtl/alu_compare_pipe_stage.sv
// ----------------------------------------------------------------------------
// cmp_pipe_stage
// Generic one-entry valid/ready register slice.
//   clk, rst_n          : clock, async active-low reset (clears valid and data)
//   in_valid/in_ready   : upstream handshake, in_data captured on transfer
//   out_valid/out_ready : downstream handshake, out_data held until taken
// in_ready depends only on the stored valid and out_ready, never on in_valid.
// ----------------------------------------------------------------------------
module cmp_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // The slot can be refilled whenever it is empty or being emptied this cycle.
  // Data only changes on a real transfer, so a stalled result stays stable.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_compare_pipe.sv
// ----------------------------------------------------------------------------
// alu_compare_pipe
// Two-stage pipelined magnitude comparator with valid/ready backpressure and
// a saturating count of true results.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_compare_pipe_if.slave
//                in_*      operands, signedness and opcode (valid/ready)
//                out_*     result, lt/eq/gt flags, reserved-op error (valid/ready)
//                cnt_clr   synchronous clear of true_count (wins over increment)
//                true_count number of taken results with out_result=1
// Stage 1 registers the guard-extended operands and the opcode; stage 2
// registers the flags and the opcode outcome.
// ----------------------------------------------------------------------------
module alu_compare_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_compare_pipe_if.slave bus
);

  localparam int XW   = WIDTH + 1;
  localparam int S1_W = 2 * XW + 3;
  localparam int S2_W = 5;

  logic [MAX_W:0]   a_full, b_full;
  logic [S1_W-1:0]  s1_in, s1_data;
  logic             s1_valid, s2_in_ready;
  logic [XW-1:0]    a_x, b_x;
  logic [2:0]       op;
  logic [XW:0]      diff;
  logic             lt, eq, gt, result, err;
  logic [S2_W-1:0]  s2_in, s2_data;
  logic [CNT_W-1:0] count_q, count_d;

  // One guard bit makes signed and unsigned operands comparable with the
  // same subtractor.
  always_comb begin
    a_full = ext_operand(MAX_W'(bus.in_a), WIDTH, bus.in_signed);
    b_full = ext_operand(MAX_W'(bus.in_b), WIDTH, bus.in_signed);
    s1_in  = {a_full[WIDTH:0], b_full[WIDTH:0], bus.in_op};
  end

  cmp_pipe_stage #(.DATA_W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  // A second extension bit keeps the difference from wrapping, so its MSB is
  // a reliable "A below B" indication even for most-negative vs most-positive.
  always_comb begin
    a_x    = s1_data[S1_W-1 -: XW];
    b_x    = s1_data[3 +: XW];
    op     = s1_data[2:0];
    diff   = {a_x[XW-1], a_x} - {b_x[XW-1], b_x};
    lt     = diff[XW];
    eq     = (a_x == b_x);
    gt     = !lt && !eq;
    result = 1'b0;
    err    = 1'b0;
    case (op)
      CMP_LT:  result = lt;
      CMP_LE:  result = lt || eq;
      CMP_EQ:  result = eq;
      CMP_NE:  result = !eq;
      CMP_GT:  result = gt;
      CMP_GE:  result = !lt;
      default: err    = 1'b1;
    endcase
    s2_in = {result, lt, eq, gt, err};
  end

  cmp_pipe_stage #(.DATA_W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_data)
  );

  assign {bus.out_result, bus.out_lt, bus.out_eq, bus.out_gt, bus.out_err} = s2_data;

  // Count only results actually taken downstream; clear beats increment.
  always_comb begin
    count_d = count_q;
    if (bus.cnt_clr) begin
      count_d = '0;
    end else if (bus.out_valid && bus.out_ready && bus.out_result) begin
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.true_count = count_q;

endmodule

// File: tb/tb_alu_compare_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_compare_pipe
// Directed and randomized checks of alu_compare_pipe (WIDTH=6, CNT_W=2)
// against an in-bench reference built from plain integer comparisons and a
// queue of in-flight transactions.
// ----------------------------------------------------------------------------
module tb_alu_compare_pipe;

  localparam int W       = 6;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic res;
    logic lt;
    logic eq;
    logic gt;
    logic err;
    int   acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   cnt_m;
  exp_t exp_q[$];

  alu_compare_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_compare_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: interpret operands as integers and compare them directly.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, input logic [2:0] op, input int acc);
    exp_t e;
    int   ai;
    int   bi;
    ai = int'(a);
    bi = int'(b);
    if (sgn && a[W-1]) ai = ai - (1 << W);
    if (sgn && b[W-1]) bi = bi - (1 << W);
    e.lt  = (ai < bi);
    e.eq  = (ai == bi);
    e.gt  = (ai > bi);
    e.err = (op > 3'd5);
    case (op)
      3'd0:    e.res = (ai < bi);
      3'd1:    e.res = (ai <= bi);
      3'd2:    e.res = (ai == bi);
      3'd3:    e.res = (ai != bi);
      3'd4:    e.res = (ai > bi);
      3'd5:    e.res = (ai >= bi);
      default: e.res = 1'b0;
    endcase
    e.acc = acc;
    return e;
  endfunction

  // Compare process: every falling edge, check the DUT against the reference,
  // then advance the reference by the transfers the next rising edge will make.
  always @(negedge clk) begin : monitor
    exp_t head;
    logic exp_ov;
    logic hs_out;
    if (!rst_n) begin
      exp_q.delete();
      cnt_m = 0;
    end else begin
      checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2 || bus.out_ready));
      exp_ov = 1'b0;
      if (exp_q.size() > 0) exp_ov = ((cyc - exp_q[0].acc) >= 1);
      checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (bus.out_valid && exp_q.size() > 0) begin
        head = exp_q[0];
        checkOutput("out_result", 32'(bus.out_result), 32'(head.res));
        checkOutput("out_lt",     32'(bus.out_lt),     32'(head.lt));
        checkOutput("out_eq",     32'(bus.out_eq),     32'(head.eq));
        checkOutput("out_gt",     32'(bus.out_gt),     32'(head.gt));
        checkOutput("out_err",    32'(bus.out_err),    32'(head.err));
      end
      checkOutput("true_count", 32'(bus.true_count), 32'(cnt_m));
      hs_out = bus.out_valid && bus.out_ready && (exp_q.size() > 0);
      if (bus.cnt_clr) cnt_m = 0;
      else if (hs_out && exp_q[0].res && cnt_m < CNT_MAX) cnt_m = cnt_m + 1;
      if (hs_out) void'(exp_q.pop_front());
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_signed, bus.in_op, cyc + 1));
    end
  end

  // Present one transaction (caller is just past a rising edge) and return
  // just past the edge that accepted it; in_valid is left high.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sgn, input logic [2:0] op);
    bit done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_signed = sgn;
    bus.in_op    = op;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop in_valid and stop at the falling edge where a result is shown.
  task automatic waitResult();
    bit found;
    found        = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    if (!found) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL result_timeout: out_valid stayed 0, required 1");
    end
  endtask

  task automatic pulseClear();
    @(posedge clk);
    #1 bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1 bus.cnt_clr = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int c0;
    int c_first;
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    cnt_m         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.in_op     = 3'd0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_out_valid",  32'(bus.out_valid),  32'd0);
    checkOutput("rst_out_result", 32'(bus.out_result), 32'd0);
    checkOutput("rst_out_lt",     32'(bus.out_lt),     32'd0);
    checkOutput("rst_out_eq",     32'(bus.out_eq),     32'd0);
    checkOutput("rst_out_gt",     32'(bus.out_gt),     32'd0);
    checkOutput("rst_out_err",    32'(bus.out_err),    32'd0);
    checkOutput("rst_true_count", 32'(bus.true_count), 32'd0);
    checkOutput("rst_in_ready",   32'(bus.in_ready),   32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Most negative vs most positive, signed then unsigned
    applyStimulus(6'b100000, 6'b011111, 1'b1, 3'd0);
    waitResult();
    checkOutput("t1_s_result", 32'(bus.out_result), 32'd1);
    checkOutput("t1_s_lt",     32'(bus.out_lt),     32'd1);
    @(posedge clk); #1;
    applyStimulus(6'b100000, 6'b011111, 1'b0, 3'd0);
    waitResult();
    checkOutput("t1_u_result", 32'(bus.out_result), 32'd0);
    checkOutput("t1_u_gt",     32'(bus.out_gt),     32'd1);
    @(posedge clk); #1;

    // Equal operands in both modes, EQ and NE
    applyStimulus(6'h2A, 6'h2A, 1'b0, 3'd2);
    waitResult();
    checkOutput("t2_u_eq",     32'(bus.out_eq),     32'd1);
    checkOutput("t2_u_result", 32'(bus.out_result), 32'd1);
    @(posedge clk); #1;
    applyStimulus(6'h2A, 6'h2A, 1'b1, 3'd2);
    waitResult();
    checkOutput("t2_s_eq",     32'(bus.out_eq),     32'd1);
    checkOutput("t2_s_result", 32'(bus.out_result), 32'd1);
    @(posedge clk); #1;
    applyStimulus(6'h2A, 6'h2A, 1'b1, 3'd3);
    waitResult();
    checkOutput("t2_ne_result", 32'(bus.out_result), 32'd0);
    idleCycles(3);

    // Back-to-back burst: latency 2, contiguous results
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)));
        bus.in_valid = 1'b0;
      end
      begin
        bit seen;
        seen    = 1'b0;
        c_first = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen    = 1'b1;
            c_first = cyc;
          end
        end
        checkOutput("t3_latency", 32'(c_first - c0), 32'd2);
        for (int i = 1; i < 8; i++) begin
          @(negedge clk);
          checkOutput("t3_contiguous", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        checkOutput("t3_end", 32'(bus.out_valid), 32'd0);
      end
    join
    idleCycles(3);

    // Backpressure: three sends with out_ready low, then release
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus(6'd5, 6'd9, 1'b0, 3'd0);
        applyStimulus(6'd9, 6'd5, 1'b0, 3'd4);
        applyStimulus(6'd7, 6'd7, 1'b0, 3'd5);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        checkOutput("t4_in_ready",  32'(bus.in_ready),   32'd0);
        checkOutput("t4_valid",     32'(bus.out_valid),  32'd1);
        checkOutput("t4_lt",        32'(bus.out_lt),     32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t4_hold_lt",    32'(bus.out_lt),    32'd1);
        checkOutput("t4_hold_res",   32'(bus.out_result), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idleCycles(5);
    checkOutput("t4_count_sat", 32'(bus.true_count), 32'd3);

    // Reserved opcodes flow with err set and never count
    pulseClear();
    applyStimulus(6'h15, 6'h15, 1'b1, 3'b110);
    waitResult();
    checkOutput("t5_err",    32'(bus.out_err),    32'd1);
    checkOutput("t5_result", 32'(bus.out_result), 32'd0);
    checkOutput("t5_eq",     32'(bus.out_eq),     32'd1);
    @(posedge clk); #1;
    applyStimulus(6'd1, 6'd2, 1'b0, 3'b111);
    waitResult();
    checkOutput("t5_err7",    32'(bus.out_err),    32'd1);
    checkOutput("t5_result7", 32'(bus.out_result), 32'd0);
    idleCycles(3);
    checkOutput("t5_count_unchanged", 32'(bus.true_count), 32'd0);
    applyStimulus(6'd3, 6'd3, 1'b0, 3'd2);
    idleCycles(4);
    checkOutput("t5_count_one", 32'(bus.true_count), 32'd1);

    // Reset in the middle of a stall
    bus.out_ready = 1'b0;
    applyStimulus(6'd1, 6'd2, 1'b0, 3'd0);
    applyStimulus(6'd2, 6'd1, 1'b0, 3'd4);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 32'(bus.out_valid),  32'd0);
    checkOutput("t5_rst_count", 32'(bus.true_count), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Saturation at 3, then clear coinciding with a true handshake
    applyStimulus(6'd1, 6'd2, 1'b0, 3'd0);
    applyStimulus(6'd3, 6'd3, 1'b0, 3'd5);
    applyStimulus(6'd4, 6'd5, 1'b1, 3'd3);
    applyStimulus(6'd9, 6'd1, 1'b0, 3'd4);
    applyStimulus(6'd2, 6'd2, 1'b1, 3'd1);
    idleCycles(4);
    checkOutput("t6_saturate", 32'(bus.true_count), 32'd3);
    applyStimulus(6'd0, 6'd0, 1'b0, 3'd2);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.cnt_clr = 1'b1;
    @(negedge clk);
    checkOutput("t6_clr_valid",  32'(bus.out_valid),  32'd1);
    checkOutput("t6_clr_result", 32'(bus.out_result), 32'd1);
    @(posedge clk);
    #1 bus.cnt_clr = 1'b0;
    @(negedge clk);
    checkOutput("t6_clr_count", 32'(bus.true_count), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and occasional clears
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 1) ? 6'b100000 : 6'b011111;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? 6'b111111 : 6'b000000;
      if ($urandom_range(0, 9) == 0) rb = ra;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = ra;
      bus.in_b      = rb;
      bus.in_signed = 1'($urandom_range(0, 1));
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.cnt_clr   = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
    idleCycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
